// File: rtl/axis_ema_arbiter.sv
// Packet-level round-robin arbiter feeding one EMA AXI-Stream datapath from NUM_SRC sources.
// Optional per-source completed-packet counters are enabled with `define AXIS_EMA_ARB_PKTCNT_EN.
module axis_ema_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEST_W  = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [32*NUM_SRC-1:0]   S_AXIS_TDATA,
    input  logic [4*NUM_SRC-1:0]    S_AXIS_TKEEP,
    input  logic [NUM_SRC-1:0]      S_AXIS_TLAST,
    input  logic [NUM_SRC-1:0]      S_AXIS_TVALID,
    output logic [NUM_SRC-1:0]      S_AXIS_TREADY,
    output logic [31:0]             M_AXIS_TDATA,
    output logic [3:0]              M_AXIS_TKEEP,
    output logic                    M_AXIS_TLAST,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic [DEST_W-1:0]       M_AXIS_TDEST
`ifdef AXIS_EMA_ARB_PKTCNT_EN
    ,
    output logic [16*NUM_SRC-1:0]   PKT_CNT,
    input  logic                    PKT_CNT_CLR
`endif
);

    // state | meaning
    // IDLE  | no grant held; scan TVALID from rr_ptr and latch the first requester
    // BUSY  | granted source passed straight through until its TLAST handshake

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [DEST_W-1:0] grant_q, grant_d;
    logic [DEST_W-1:0] rr_ptr_q, rr_ptr_d;
    logic              found;
    int                scan_idx;
    logic              last_hs;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Datapath: pure mux while BUSY, everything quiet while IDLE.
    always_comb begin
        M_AXIS_TDATA  = '0;
        M_AXIS_TKEEP  = '0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TVALID = 1'b0;
        S_AXIS_TREADY = '0;
        if (state_q == BUSY) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == DEST_W'(i)) begin
                    M_AXIS_TDATA     = S_AXIS_TDATA[32*i +: 32];
                    M_AXIS_TKEEP     = S_AXIS_TKEEP[4*i +: 4];
                    M_AXIS_TLAST     = S_AXIS_TLAST[i];
                    M_AXIS_TVALID    = S_AXIS_TVALID[i];
                    S_AXIS_TREADY[i] = M_AXIS_TREADY;
                end
            end
        end
    end

    assign M_AXIS_TDEST = grant_q;
    assign last_hs      = (state_q == BUSY) && M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        scan_idx = 0;
        case (state_q)
            IDLE: begin
                // Wrap is done on integers so a NUM_SRC below 2**DEST_W never aliases.
                for (int k = 0; k < NUM_SRC; k++) begin
                    scan_idx = int'(rr_ptr_q) + k;
                    if (scan_idx >= NUM_SRC) begin
                        scan_idx = scan_idx - NUM_SRC;
                    end
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (!found && (scan_idx == i) && S_AXIS_TVALID[i]) begin
                            found   = 1'b1;
                            grant_d = DEST_W'(i);
                        end
                    end
                end
                if (found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == DEST_W'(NUM_SRC-1)) ? '0 : grant_q + DEST_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AXIS_EMA_ARB_PKTCNT_EN
    logic [15:0] pkt_cnt_q [NUM_SRC];
    logic [15:0] pkt_cnt_d [NUM_SRC];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if (PKT_CNT_CLR) begin
                pkt_cnt_d[i] = '0;
            end else if (last_hs && (grant_q == DEST_W'(i))) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!ARESETN) begin
                pkt_cnt_q[i] <= '0;
            end else begin
                pkt_cnt_q[i] <= pkt_cnt_d[i];
            end
        end
    end

    always_comb begin
        PKT_CNT = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            PKT_CNT[16*i +: 16] = pkt_cnt_q[i];
        end
    end
`endif

endmodule
